// File: rtl/uart_pkg.sv
// Shared types and range constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int unsigned DATA_BITS_MIN = 5;
  localparam int unsigned DATA_BITS_MAX = 9;
  localparam int unsigned STOP_BITS_MIN = 1;
  localparam int unsigned STOP_BITS_MAX = 2;

  // Wide enough to index any legal payload bit
  localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS_MAX);

endpackage

// File: rtl/rise_detect.sv
// Single-cycle pulse on each rising edge of a clk-synchronous input.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic prev;

  // Reset high so an input already high at release does not look like an edge
  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b1;
    else     prev <= in;
  end

  assign pulse = in & ~prev;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART frame serializer: start, LSB-first data, optional parity, stop bits,
// with every bit boundary aligned to a rising edge of the divided baud clock.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_clk,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned CNT_W = BIT_CNT_W;

  tx_state_e            state;
  logic [DATA_BITS-1:0] shreg;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 stop_cnt;
  logic                 parity;
  logic                 tick;

  rise_detect u_baud_rise (
    .clk   (clk),
    .rst   (rst),
    .in    (baud_clk),
    .pulse (tick)
  );

  // Frame sequencer; tx only changes on a baud tick, except on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      parity   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (tx_valid) begin
            shreg  <= tx_data;
            parity <= (^tx_data) ^ 1'(PARITY_ODD);
            state  <= SYNC;
          end
        end
        SYNC: begin
          if (tick) begin
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
              if (PARITY_EN != 0) begin
                tx    <= parity;
                state <= PARITY;
              end else begin
                tx       <= 1'b1;
                stop_cnt <= 1'b0;
                state    <= STOP;
              end
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        PARITY: begin
          if (tick) begin
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              tx    <= 1'b1;
              state <= IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench: four serializer configurations sharing clk, reset and baud clock.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] baud_cnt = 3'd0;
  logic       baud_clk;
  logic [7:0] tx_data;
  logic [3:0] valid_v;
  wire  [3:0] ready_v;
  wire  [3:0] tx_v;
  wire  [3:0] busy_v;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Baud clock period is 8 clk, synchronous to clk
  always @(posedge clk) baud_cnt <= baud_cnt + 3'd1;
  assign baud_clk = baud_cnt[2];

  uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .baud_clk(baud_clk), .tx_data(tx_data), .tx_valid(valid_v[0]),
    .tx_ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]));

  uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .baud_clk(baud_clk), .tx_data(tx_data), .tx_valid(valid_v[1]),
    .tx_ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]));

  uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .baud_clk(baud_clk), .tx_data(tx_data), .tx_valid(valid_v[2]),
    .tx_ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]));

  uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst(rst), .baud_clk(baud_clk), .tx_data(tx_data), .tx_valid(valid_v[3]),
    .tx_ready(ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int idx, input logic [7:0] d);
    tx_data      = d;
    valid_v[idx] = 1'b1;
    @(negedge clk);
    valid_v[idx] = 1'b0;
  endtask

  // bits[0] is the start bit; each bit must hold for exactly 8 clk samples
  task automatic run_frame(input int idx, input logic [15:0] bits, input int nbits,
                           input string tag);
    int         t = 0;
    logic [7:0] smp;
    while (tx_v[idx] !== 1'b0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_start_seen"}, 32'(tx_v[idx]), 32'd0);
    for (int b = 0; b < nbits; b++) begin
      smp = '0;
      for (int s = 0; s < 8; s++) begin
        if (b != 0 || s != 0) @(negedge clk);
        smp[s] = tx_v[idx];
      end
      chk($sformatf("%s_bit%0d", tag, b), 32'(smp), 32'({8{bits[b]}}));
    end
    @(negedge clk);
    chk({tag, "_ready_after"}, 32'(ready_v[idx]), 32'd1);
    chk({tag, "_busy_after"}, 32'(busy_v[idx]), 32'd0);
  endtask

  initial begin
    logic [7:0] smp;
    int         t;
    int         highs;

    rst     = 1'b1;
    valid_v = 4'b1000;
    tx_data = 8'h5A;
    repeat (4) @(negedge clk);

    // Release reset while baud_clk is already high
    while (baud_cnt != 3'd4) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_tx%0d", i), 32'(tx_v[i]), 32'd1);
      chk($sformatf("rst_ready%0d", i), 32'(ready_v[i]), 32'd1);
      chk($sformatf("rst_busy%0d", i), 32'(busy_v[i]), 32'd0);
    end

    @(negedge clk);
    valid_v = 4'b0000;
    chk("post_rst_ready0", 32'(ready_v[0]), 32'd1);
    chk("post_rst_busy0", 32'(busy_v[0]), 32'd0);
    chk("n2_accept_busy", 32'(busy_v[3]), 32'd1);
    smp = '0;
    for (int s = 0; s < 8; s++) begin
      if (s != 0) @(negedge clk);
      smp[s] = tx_v[3];
    end
    chk("n2_sync_hold", 32'(smp), 32'hFF);
    @(negedge clk);
    chk("n2_start_edge", 32'(tx_v[3]), 32'd0);
    run_frame(3, 16'({2'b11, 8'h5A, 1'b0}), 11, "n2_5a");

    // 8N1 0xA5
    send(0, 8'hA5);
    run_frame(0, 16'({1'b1, 8'hA5, 1'b0}), 10, "a5");

    // Parity: 0x07 has three ones
    send(1, 8'h07);
    run_frame(1, 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11, "par_even");
    send(2, 8'h07);
    run_frame(2, 16'({1'b1, 1'b0, 8'h07, 1'b0}), 11, "par_odd");

    // tx_valid held with 0x3C during a 0xFF frame
    tx_data    = 8'hFF;
    valid_v[0] = 1'b1;
    @(negedge clk);
    tx_data = 8'h3C;
    chk("ff_busy", 32'(busy_v[0]), 32'd1);
    run_frame(0, 16'({1'b1, 8'hFF, 1'b0}), 10, "ff_held");
    @(negedge clk);
    chk("3c_accept_busy", 32'(busy_v[0]), 32'd1);
    valid_v[0] = 1'b0;
    run_frame(0, 16'({1'b1, 8'h3C, 1'b0}), 10, "3c");

    // Reset pulse in the middle of data bit 3 of 0x96
    send(0, 8'h96);
    t = 0;
    while (tx_v[0] !== 1'b0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("abort_start_seen", 32'(tx_v[0]), 32'd0);
    repeat (35) @(negedge clk);
    chk("abort_mid_bit3_busy", 32'(busy_v[0]), 32'd1);
    chk("abort_mid_bit3_tx", 32'(tx_v[0]), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_tx", 32'(tx_v[0]), 32'd1);
    chk("abort_busy", 32'(busy_v[0]), 32'd0);
    chk("abort_ready", 32'(ready_v[0]), 32'd1);
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_v[0] === 1'b1 && busy_v[0] === 1'b0) highs++;
    end
    chk("abort_quiet", 32'(highs), 32'd40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
